// File: rtl/uart_tx_arbiter_if.sv
// Bus bundle between the byte-stream clients, the arbiter and the UART.
// The slave view belongs to the arbiter; the master view is the client/UART side.
interface uart_tx_arbiter_if #(
  parameter int N_CLIENTS = 4
);
  // client side
  logic [N_CLIENTS-1:0]   req_valid_i;
  logic [8*N_CLIENTS-1:0] req_data_i;
  logic [N_CLIENTS-1:0]   req_last_i;
  logic [N_CLIENTS-1:0]   req_ready_o;
  logic [2*N_CLIENTS-1:0] cfg_rate_i;
  // UART side
  logic                   tx_valid_o;
  logic [7:0]             tx_data_o;
  logic                   tx_ready_i;
  logic [1:0]             rate_o;

  modport slave (
    input  req_valid_i, req_data_i, req_last_i, cfg_rate_i, tx_ready_i,
    output req_ready_o, tx_valid_o, tx_data_o, rate_o
  );

  modport master (
    output req_valid_i, req_data_i, req_last_i, cfg_rate_i, tx_ready_i,
    input  req_ready_o, tx_valid_o, tx_data_o, rate_o
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N byte-stream clients.
// A grant is held for one packet (up to req_last), at most MAX_BURST bytes, or
// until the owner stays silent for IDLE_TIMEOUT cycles. The owner's rate code is
// captured at grant time so the UART rate never moves while a frame is in flight.
module uart_tx_arbiter #(
  parameter int N_CLIENTS    = 4,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  uart_tx_arbiter_if.slave     bus,
  output logic [N_CLIENTS-1:0] grant_o,
  output logic                 busy_o
);

  localparam int         IDX_W      = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);
  localparam logic [7:0] IDLE_TO_C   = 8'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SEND  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [N_CLIENTS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]     last_grant_q, last_grant_d;  // also the owner index while granted
  logic [1:0]           rate_q, rate_d;
  logic [7:0]           beat_q, beat_d;
  logic [7:0]           idle_q, idle_d;
  logic                 drain_wait_q, drain_wait_d;

  logic                 pick_found_s;
  logic [IDX_W-1:0]     pick_idx_s;
  logic                 own_valid_s;
  logic                 own_last_s;
  logic [7:0]           own_data_s;
  logic                 xfer_s;
  logic                 tx_valid_s;
  logic [7:0]           tx_data_s;
  logic [N_CLIENTS-1:0] req_ready_s;

  // First requester after 'last', wrapping; MSB of the result flags a hit.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_CLIENTS-1:0] valid,
                                             input logic [IDX_W-1:0]     last);
    logic [IDX_W:0] res;
    int             idx;
    res = '0;
    // Walk offsets from farthest to nearest so the nearest requester wins.
    for (int i = N_CLIENTS; i >= 1; i--) begin
      idx = (int'(last) + i) % N_CLIENTS;
      if (valid[idx[IDX_W-1:0]]) begin
        res = {1'b1, idx[IDX_W-1:0]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Round-robin candidate and the owner's view of the client bus.
  always_comb begin
    {pick_found_s, pick_idx_s} = rr_pick(bus.req_valid_i, last_grant_q);
    own_valid_s = bus.req_valid_i[last_grant_q];
    own_last_s  = bus.req_last_i[last_grant_q];
    own_data_s  = bus.req_data_i[{last_grant_q, 3'b000} +: 8];
    xfer_s      = (state_q == ST_SEND) && own_valid_s && bus.tx_ready_i;
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and grant/counter bookkeeping.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    rate_d       = rate_q;
    beat_d       = beat_q;
    idle_d       = idle_q;
    drain_wait_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found_s) begin
          grant_d      = {{(N_CLIENTS-1){1'b0}}, 1'b1} << pick_idx_s;
          last_grant_d = pick_idx_s;
          rate_d       = bus.cfg_rate_i[{pick_idx_s, 1'b0} +: 2];
          beat_d       = 8'd0;
          idle_d       = 8'd0;
          state_d      = ST_SETUP;
        end else begin
          grant_d = '0;
        end
      end
      ST_SETUP: begin
        // Rate has been on rate_o for a cycle; data may now flow.
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (xfer_s) begin
          beat_d = beat_q + 8'd1;
          idle_d = 8'd0;
          if (own_last_s || ((beat_q + 8'd1) == MAX_BURST_C)) begin
            state_d      = ST_DRAIN;
            drain_wait_d = 1'b1;
          end else begin
            state_d = ST_SEND;
          end
        end else if (!own_valid_s) begin
          if ((idle_q + 8'd1) == IDLE_TO_C) begin
            // Silent owner: nothing in flight, release without draining.
            state_d = ST_IDLE;
            grant_d = '0;
            idle_d  = 8'd0;
          end else begin
            idle_d = idle_q + 8'd1;
          end
        end else begin
          // Valid but UART busy: the owner is active, not idle.
          idle_d = 8'd0;
        end
      end
      ST_DRAIN: begin
        // tx_ready_i only falls the cycle after acceptance, so skip one cycle
        // before trusting it as "frame complete".
        if (drain_wait_q) begin
          state_d = ST_DRAIN;
        end else if (bus.tx_ready_i) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Grant, rate and counter registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      grant_q      <= '0;
      last_grant_q <= IDX_W'(N_CLIENTS - 1);
      rate_q       <= 2'd0;
      beat_q       <= 8'd0;
      idle_q       <= 8'd0;
      drain_wait_q <= 1'b0;
    end else begin
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      rate_q       <= rate_d;
      beat_q       <= beat_d;
      idle_q       <= idle_d;
      drain_wait_q <= drain_wait_d;
    end
  end

  // Output decode: zero-latency pass-through of the owner while sending.
  always_comb begin
    tx_valid_s  = 1'b0;
    tx_data_s   = 8'h00;
    req_ready_s = '0;
    if (state_q == ST_SEND) begin
      tx_valid_s                = own_valid_s;
      tx_data_s                 = own_valid_s ? own_data_s : 8'h00;
      req_ready_s[last_grant_q] = bus.tx_ready_i;
    end else begin
      tx_valid_s  = 1'b0;
      tx_data_s   = 8'h00;
      req_ready_s = '0;
    end
  end

  assign bus.tx_valid_o  = tx_valid_s;
  assign bus.tx_data_o   = tx_data_s;
  assign bus.req_ready_o = req_ready_s;
  assign bus.rate_o      = rate_q;
  assign grant_o         = grant_q;
  assign busy_o          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple UART ready model.
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int FRAME = 4;  // cycles the UART model stays busy per byte

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_CLIENTS(N)) bus ();
  logic [N-1:0] grant;
  logic         busy;

  uart_tx_arbiter #(.N_CLIENTS(N), .MAX_BURST(4), .IDLE_TIMEOUT(64)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus),
    .grant_o (grant),
    .busy_o  (busy)
  );

  int checks = 0;
  int errors = 0;

  // UART model: ready drops the cycle after an accepted byte, for FRAME cycles.
  logic uart_ready = 1'b1;
  int   uart_cnt   = 0;
  logic xfer_n     = 1'b0;
  assign bus.tx_ready_i = uart_ready;

  always @(posedge clk) begin
    if (xfer_n) begin
      uart_ready <= 1'b0;
      uart_cnt   <= FRAME;
    end else if (uart_cnt > 0) begin
      uart_cnt <= uart_cnt - 1;
      if (uart_cnt == 1) uart_ready <= 1'b1;
    end
  end

  // Monitor: log transfers, watch data-zeroing and rate stability.
  logic [7:0]   log_data [$];
  logic [N-1:0] log_grant[$];
  logic [1:0]   log_rate [$];
  int           viol_zero = 0;
  int           viol_rate = 0;
  logic [1:0]   prev_rate = 2'd0;
  logic         prev_busy = 1'b0;

  always @(negedge clk) begin
    xfer_n <= bus.tx_valid_o & bus.tx_ready_i;
    if (bus.tx_valid_o && bus.tx_ready_i) begin
      log_data.push_back(bus.tx_data_o);
      log_grant.push_back(grant);
      log_rate.push_back(bus.rate_o);
    end
    if (!bus.tx_valid_o && (bus.tx_data_o !== 8'h00)) viol_zero <= viol_zero + 1;
    if (busy && prev_busy && (bus.rate_o !== prev_rate)) viol_rate <= viol_rate + 1;
    prev_rate <= bus.rate_o;
    prev_busy <= busy;
  end

  // Client byte tables
  logic [7:0] cdata[N][16];
  logic       clast[N][16];
  int         cnum[N];
  int         cpos[N];
  int         log_base = 0;

  logic [7:0]   exp3_d[12];
  logic [N-1:0] exp3_g[12];
  logic [7:0]   exp2_d[5];
  logic [N-1:0] exp2_g[5];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_clients();
    for (int k = 0; k < N; k++) begin
      if (cpos[k] < cnum[k]) begin
        bus.req_valid_i[k]       = 1'b1;
        bus.req_data_i[8*k +: 8] = cdata[k][cpos[k]];
        bus.req_last_i[k]        = clast[k][cpos[k]];
      end else begin
        bus.req_valid_i[k]       = 1'b0;
        bus.req_data_i[8*k +: 8] = 8'h00;
        bus.req_last_i[k]        = 1'b0;
      end
    end
  endtask

  function automatic int remaining(input logic [N-1:0] mask);
    int r = 0;
    for (int k = 0; k < N; k++) if (mask[k]) r += cnum[k] - cpos[k];
    return r;
  endfunction

  task automatic clear_clients();
    for (int k = 0; k < N; k++) begin
      cnum[k] = 0;
      cpos[k] = 0;
    end
    drive_clients();
  endtask

  // Drive client tables until every client in mask has sent its bytes.
  task automatic run(input logic [N-1:0] mask, input int budget, input string tag);
    int           cyc = 0;
    logic [N-1:0] acc;
    while (1) begin
      drive_clients();
      if (remaining(mask) == 0 || cyc >= budget) break;
      @(negedge clk);
      acc = bus.req_valid_i & bus.req_ready_o;
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) if (acc[k]) cpos[k]++;
      cyc++;
    end
    check({tag, "_bytes_left"}, 32'(remaining(mask)), 32'd0);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int cyc = 0;
    @(negedge clk);
    while (busy && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_clients();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    log_base = log_data.size();
  endtask

  initial begin
    int cnt;

    // ---- reset with random inputs
    bus.req_valid_i = N'($urandom);
    bus.req_data_i  = $urandom;
    bus.req_last_i  = N'($urandom);
    bus.cfg_rate_i  = 8'($urandom);
    repeat (2) @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_tx_valid", 32'(bus.tx_valid_o), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data_o), 32'd0);
    check("rst_rate", 32'(bus.rate_o), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready_o), 32'd0);

    // ---- single client 2, rate 1, three bytes; rate change mid-grant ignored
    do_reset();
    bus.cfg_rate_i = 8'h10;
    cdata[2][0] = 8'h0F; clast[2][0] = 1'b0;
    cnum[2] = 1;
    run(4'b0100, 50, "c2_first");
    bus.cfg_rate_i = 8'h30;
    cdata[2][1] = 8'h55; clast[2][1] = 1'b0;
    cdata[2][2] = 8'hA5; clast[2][2] = 1'b1;
    cnum[2] = 3;
    run(4'b0100, 50, "c2_rest");
    @(negedge clk);
    check("c2_grant_drain", 32'(grant), 32'h4);
    wait_idle(30, "c2");
    check("c2_grant_after", 32'(grant), 32'h0);
    check("c2_count", 32'(log_data.size() - log_base), 32'd3);
    if (log_data.size() - log_base == 3) begin
      check("c2_b0", 32'(log_data[log_base+0]), 32'h0F);
      check("c2_b1", 32'(log_data[log_base+1]), 32'h55);
      check("c2_b2", 32'(log_data[log_base+2]), 32'hA5);
      for (int i = 0; i < 3; i++) begin
        check($sformatf("c2_g%0d", i), 32'(log_grant[log_base+i]), 32'h4);
        check($sformatf("c2_r%0d", i), 32'(log_rate[log_base+i]), 32'd1);
      end
    end

    // ---- four clients, 1-byte packets: order 0,1,2,3,0
    do_reset();
    bus.cfg_rate_i = 8'h00;
    for (int k = 0; k < N; k++) begin
      cdata[k][0] = 8'h10 + 8'(k);
      clast[k][0] = 1'b1;
      cnum[k]     = 1;
    end
    cdata[0][1] = 8'h50; clast[0][1] = 1'b1; cnum[0] = 2;
    exp2_d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h50};
    exp2_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    run(4'b1111, 200, "rr");
    wait_idle(30, "rr");
    check("rr_count", 32'(log_data.size() - log_base), 32'd5);
    if (log_data.size() - log_base == 5) begin
      for (int i = 0; i < 5; i++) begin
        check($sformatf("rr_d%0d", i), 32'(log_data[log_base+i]), 32'(exp2_d[i]));
        check($sformatf("rr_g%0d", i), 32'(log_grant[log_base+i]), 32'(exp2_g[i]));
      end
    end

    // ---- MAX_BURST=4: client 1 streams 10 bytes, clients 2/3 interleave
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cdata[1][i] = 8'h20 + 8'(i);
      clast[1][i] = 1'b0;
    end
    cnum[1] = 10;
    cdata[2][0] = 8'h32; clast[2][0] = 1'b1; cnum[2] = 1;
    cdata[3][0] = 8'h43; clast[3][0] = 1'b1; cnum[3] = 1;
    exp3_d = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h32, 8'h43,
               8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h29};
    exp3_g = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b1000,
               4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
    run(4'b1110, 400, "burst");
    wait_idle(200, "burst");
    check("burst_count", 32'(log_data.size() - log_base), 32'd12);
    if (log_data.size() - log_base == 12) begin
      for (int i = 0; i < 12; i++) begin
        check($sformatf("burst_d%0d", i), 32'(log_data[log_base+i]), 32'(exp3_d[i]));
        check($sformatf("burst_g%0d", i), 32'(log_grant[log_base+i]), 32'(exp3_g[i]));
      end
    end

    // ---- idle timeout: client 0 goes silent, waiting client 3 is next
    do_reset();
    cdata[0][0] = 8'h60; clast[0][0] = 1'b0; cnum[0] = 1;
    cdata[3][0] = 8'h73; clast[3][0] = 1'b1; cnum[3] = 1;
    run(4'b0001, 50, "to_c0");
    cnt = 0;
    while (cnt < 200) begin
      @(negedge clk);
      if (grant !== 4'b0001) break;
      cnt++;
    end
    check("to_hold_cycles", 32'(cnt), 32'd64);
    run(4'b1000, 100, "to_c3");
    wait_idle(30, "to");
    check("to_count", 32'(log_data.size() - log_base), 32'd2);
    if (log_data.size() - log_base == 2) begin
      check("to_c3_data", 32'(log_data[log_base+1]), 32'h73);
      check("to_c3_grant", 32'(log_grant[log_base+1]), 32'h8);
    end

    // ---- asynchronous reset mid-SEND
    do_reset();
    bus.cfg_rate_i = 8'h08;
    cdata[1][0] = 8'h81; clast[1][0] = 1'b0; cnum[1] = 1;
    run(4'b0010, 50, "ar_c1");
    cdata[1][1] = 8'h82; clast[1][1] = 1'b0; cnum[1] = 2;
    drive_clients();
    @(negedge clk);
    check("ar_pre_tx_valid", 32'(bus.tx_valid_o), 32'd1);
    check("ar_pre_grant", 32'(grant), 32'h2);
    check("ar_pre_rate", 32'(bus.rate_o), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_grant", 32'(grant), 32'h0);
    check("ar_tx_valid", 32'(bus.tx_valid_o), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_rate", 32'(bus.rate_o), 32'd0);
    check("ar_req_ready", 32'(bus.req_ready_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    log_base = log_data.size();
    cdata[0][0] = 8'h90; clast[0][0] = 1'b1; cnum[0] = 1; cpos[0] = 0;
    run(4'b0001, 60, "ar_c0");
    check("ar_post_count", 32'(log_data.size() > log_base), 32'd1);
    if (log_data.size() > log_base) begin
      check("ar_post_grant", 32'(log_grant[log_base]), 32'h1);
      check("ar_post_data", 32'(log_data[log_base]), 32'h90);
    end

    // ---- global rules watched by the monitor
    @(negedge clk);
    check("data_zero_when_idle", 32'(viol_zero), 32'd0);
    check("rate_stable_while_busy", 32'(viol_rate), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
